// File: rtl/dcache_pkg.sv
// Shared field widths, tag-word layout and controller states for the L1 data cache.
package dcache_pkg;

  localparam int unsigned TAG_W      = 23;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned OFS_W      = 5;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned WORDS      = LINE_W / WORD_W;
  localparam int unsigned ADDR_W     = TAG_W + IDX_W + OFS_W;
  localparam int unsigned SRAM_TAG_W = TAG_W + 2;
  localparam int unsigned VALID_BIT  = 24;
  localparam int unsigned DIRTY_BIT  = 23;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// Word select and word replace on one cache line; feeds both the load mux and the store merge.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic [LINE_W-1:0] line_c_o
);

  // Pick the selected word out and splice the new word into the same slot.
  always_comb begin
    word_c_o = '0;
    line_c_o = line_i;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (sel_i == SEL_W'(w)) begin
        word_c_o                      = line_i[w*WORD_W +: WORD_W];
        line_c_o[w*WORD_W +: WORD_W] = word_i;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// L1 data cache sequencer: SRAM lookup/store-merge, miss handling with write-back and refill, hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_write_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [WORD_W-1:0]     cpu_data_i,
  output logic [WORD_W-1:0]     cpu_data_o,
  output logic                  cpu_stall_o,
  output logic [IDX_W-1:0]      sram_addr_o,
  output logic [SRAM_TAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  input  logic [SRAM_TAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i,
  output logic [CNT_W-1:0]      hit_cnt_o,
  output logic [CNT_W-1:0]      miss_cnt_o
);

  state_e             state_q, state_d;
  logic               retry_q, retry_d;
  logic [LINE_W-1:0]  buf_q, buf_d;
  logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   cpu_idx;
  logic [SEL_W-1:0]   cpu_word;
  logic [LINE_W-1:0]  merged_line;
  logic [1:0]         unused_byte_ofs;

  assign cpu_tag         = cpu_addr_i[OFS_W+IDX_W +: TAG_W];
  assign cpu_idx         = cpu_addr_i[OFS_W +: IDX_W];
  assign cpu_word        = cpu_addr_i[2 +: SEL_W];
  assign unused_byte_ofs = cpu_addr_i[1:0];

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  dcache_word_merge u_merge (
    .line_i   (sram_data_i),
    .sel_i    (cpu_word),
    .word_i   (cpu_data_i),
    .word_c_o (cpu_data_o),
    .line_c_o (merged_line)
  );

  // State, latched miss context, line buffer and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      retry_q      <= 1'b0;
      buf_q        <= '0;
      victim_tag_q <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      buf_q        <= buf_d;
      victim_tag_q <= victim_tag_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Next-state and output decode; the SRAM is never written on an IDLE miss.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    buf_d         = buf_q;
    victim_tag_d  = victim_tag_q;
    req_tag_d     = req_tag_q;
    req_idx_d     = req_idx_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    cpu_stall_o   = 1'b1;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = req_idx_q;
    sram_tag_o    = {1'b1, 1'b0, req_tag_q};
    sram_data_o   = buf_q;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = {req_tag_q, req_idx_q, OFS_W'(0)};
    mem_data_o    = buf_q;

    case (state_q)
      S_IDLE: begin
        sram_enable_o = cpu_req_i;
        sram_addr_o   = cpu_idx;
        sram_tag_o    = {1'b1, cpu_write_i, cpu_tag};
        sram_data_o   = merged_line;
        cpu_stall_o   = cpu_req_i & ~sram_hit_i;
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            sram_write_o = cpu_write_i;
            if (!retry_q && !(&hit_cnt_q)) begin
              hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
            retry_d = 1'b0;
          end else begin
            if (!(&miss_cnt_q)) begin
              miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
            buf_d        = sram_data_i;
            victim_tag_d = sram_tag_i[TAG_W-1:0];
            req_tag_d    = cpu_tag;
            req_idx_d    = cpu_idx;
            if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
              state_d = S_WRITEBACK;
            end else begin
              state_d = S_ALLOCATE;
            end
          end
        end
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_q, req_idx_q, OFS_W'(0)};
        if (mem_ack_i) begin
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        if (mem_ack_i) begin
          buf_d   = mem_data_i;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        retry_d       = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
